// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST controller: pattern modes,
// FSM states and the Galois LFSR tap table.
package mem_bist_pkg;

   typedef enum logic [1:0] {
      CLEAR   = 2'b00,
      ADDR    = 2'b01,
      RAND    = 2'b10,
      CHECKER = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Right-shifting Galois masks for maximal-length sequences; widths outside
   // the table fall back to a short but non-degenerate polynomial.
   function automatic logic [31:0] lfsr_taps(input int unsigned w);
      logic [31:0] t;
      case (w)
         2:       t = 32'h0000_0003;
         3:       t = 32'h0000_0006;
         4:       t = 32'h0000_000C;
         5:       t = 32'h0000_0014;
         6:       t = 32'h0000_0030;
         7:       t = 32'h0000_0060;
         8:       t = 32'h0000_00B8;
         9:       t = 32'h0000_0110;
         10:      t = 32'h0000_0240;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0E08;
         13:      t = 32'h0000_1C80;
         14:      t = 32'h0000_3802;
         15:      t = 32'h0000_6000;
         16:      t = 32'h0000_D008;
         17:      t = 32'h0001_2000;
         18:      t = 32'h0002_0400;
         19:      t = 32'h0007_2000;
         20:      t = 32'h0009_0000;
         21:      t = 32'h0014_0000;
         22:      t = 32'h0030_0000;
         23:      t = 32'h0042_0000;
         24:      t = 32'h00E1_0000;
         default: t = (32'h1 << (w - 1)) | 32'h1;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Control/status and memory-port bundle for one BIST controller; the master
// side is the controller, the slave side is the test logic plus the memory.
interface mem_bist_if #(
   parameter int AW  = 5,
   parameter int DW  = 8,
   parameter int ECW = 8
);

   logic           start;
   logic [1:0]     mode;
   logic [DW-1:0]  seed;
   logic           busy;
   logic           done;
   logic           pass;
   logic [ECW-1:0] err_count;
   logic [AW-1:0]  first_err_addr;
   logic           mem_write;
   logic           mem_read;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_data_in;
   logic [DW-1:0]  mem_data_out;

   modport master (
      input  start, mode, seed, mem_data_out,
      output busy, done, pass, err_count, first_err_addr,
             mem_write, mem_read, mem_addr, mem_data_in
   );

   modport slave (
      output start, mode, seed, mem_data_out,
      input  busy, done, pass, err_count, first_err_addr,
             mem_write, mem_read, mem_addr, mem_data_in
   );

endinterface

// File: rtl/mem_bist_lfsr.sv
// Galois LFSR used for the random pattern; load has priority over step.
module mem_bist_lfsr
   import mem_bist_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] seed,
   input  logic          step,
   output logic [DW-1:0] q
);

   localparam logic [DW-1:0] TAPS = DW'(lfsr_taps(DW));

   // Reset to a non-zero state so a step without a prior load never locks up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= DW'(1);
      end else if (load) begin
         q <= seed;
      end else if (step) begin
         q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
      end
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: write-all pass, pipelined read/compare pass, then a
// done pulse with pass flag, saturating error count and first failing address.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int AW     = 5,
   parameter int DW     = 8,
   parameter int RD_LAT = 1,
   parameter int ECW    = 8
) (
   input logic        clk,
   input logic        rst,
   mem_bist_if.master bus
);

   localparam logic [AW-1:0] LAST_ADDR = '1;
   localparam logic [DW-1:0] TAPS      = DW'(lfsr_taps(DW));

   state_e         state;
   mode_e          mode_q;
   logic [DW-1:0]  seed_q;
   logic [DW-1:0]  exp_q;
   logic [2:0]     drain_cnt;

   logic           start_ok;
   logic           at_last;
   logic [AW-1:0]  addr_inc;
   logic [DW-1:0]  seed_in_fix;
   logic [DW-1:0]  rnd_next;

   logic           lfsr_load;
   logic           lfsr_step;
   logic [DW-1:0]  lfsr_seed;
   logic [DW-1:0]  lfsr_q;

   logic           pipe_v [RD_LAT];
   logic [DW-1:0]  pipe_e [RD_LAT];
   logic [AW-1:0]  pipe_a [RD_LAT];
   logic           mismatch;

   function automatic logic [DW-1:0] pattern(input mode_e m,
                                             input logic [AW-1:0] a,
                                             input logic [DW-1:0] rnd);
      logic [DW-1:0] r;
      r = '0;
      case (m)
         CLEAR:   r = '0;
         ADDR:    r = DW'(a);
         RAND:    r = rnd;
         CHECKER: begin
            for (int i = 0; i < DW; i++) begin
               r[i] = (i < (DW / 2) * 2) && ((i % 2) == 1);
            end
            if (a[0]) begin
               r = ~r;
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   assign start_ok    = (state == IDLE) && bus.start;
   assign at_last     = (bus.mem_addr == LAST_ADDR);
   assign addr_inc    = bus.mem_addr + AW'(1);
   assign seed_in_fix = (bus.seed == '0) ? DW'(1) : bus.seed;

   // The LFSR holds the value for the location currently on the bus, so the
   // registered data/expected value for the next location is one step ahead.
   assign rnd_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

   always_comb begin
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      lfsr_seed = seed_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               lfsr_load = 1'b1;
               lfsr_seed = seed_in_fix;
            end
         end
         WRITE: begin
            if (at_last) begin
               lfsr_load = 1'b1;
            end else begin
               lfsr_step = 1'b1;
            end
         end
         READ: begin
            lfsr_step = !at_last;
         end
         default: begin
            lfsr_load = 1'b0;
         end
      endcase
   end

   mem_bist_lfsr #(
      .DW(DW)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .seed (lfsr_seed),
      .step (lfsr_step),
      .q    (lfsr_q)
   );

   // Sequencer: every memory strobe, address and data word is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         mode_q          <= CLEAR;
         seed_q          <= '0;
         exp_q           <= '0;
         drain_cnt       <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.pass        <= 1'b0;
         bus.mem_write   <= 1'b0;
         bus.mem_read    <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_data_in <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state           <= WRITE;
                  mode_q          <= mode_e'(bus.mode);
                  seed_q          <= seed_in_fix;
                  bus.busy        <= 1'b1;
                  bus.pass        <= 1'b0;
                  bus.mem_write   <= 1'b1;
                  bus.mem_addr    <= '0;
                  bus.mem_data_in <= pattern(mode_e'(bus.mode), '0, seed_in_fix);
               end
            end
            WRITE: begin
               if (at_last) begin
                  state           <= READ;
                  bus.mem_write   <= 1'b0;
                  bus.mem_data_in <= '0;
                  bus.mem_read    <= 1'b1;
                  bus.mem_addr    <= '0;
                  exp_q           <= pattern(mode_q, '0, seed_q);
               end else begin
                  bus.mem_addr    <= addr_inc;
                  bus.mem_data_in <= pattern(mode_q, addr_inc, rnd_next);
               end
            end
            READ: begin
               if (at_last) begin
                  state        <= DRAIN;
                  bus.mem_read <= 1'b0;
                  bus.mem_addr <= '0;
                  exp_q        <= '0;
                  drain_cnt    <= '0;
               end else begin
                  bus.mem_addr <= addr_inc;
                  exp_q        <= pattern(mode_q, addr_inc, rnd_next);
               end
            end
            DRAIN: begin
               if (drain_cnt == 3'(RD_LAT - 1)) begin
                  state <= DONE;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               bus.pass <= (bus.err_count == '0);
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Each read's expected word travels with its strobe; the tail lines up
   // with the cycle in which the memory presents that read's data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_e[i] <= '0;
            pipe_a[i] <= '0;
         end
      end else begin
         pipe_v[0] <= bus.mem_read;
         pipe_e[0] <= exp_q;
         pipe_a[0] <= bus.mem_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
      end
   end

   assign mismatch = pipe_v[RD_LAT-1] && (bus.mem_data_out != pipe_e[RD_LAT-1]);

   // A zero error count doubles as the "no mismatch seen yet" flag, since the
   // counter saturates instead of wrapping back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.err_count      <= '0;
         bus.first_err_addr <= '0;
      end else if (start_ok) begin
         bus.err_count      <= '0;
         bus.first_err_addr <= '0;
      end else if (mismatch) begin
         if (bus.err_count != '1) begin
            bus.err_count <= bus.err_count + ECW'(1);
         end
         if (bus.err_count == '0) begin
            bus.first_err_addr <= pipe_a[RD_LAT-1];
         end
      end
   end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Two controllers (read latency 1 with 8-bit counter, read latency 3 with
// 2-bit counter) each driving a behavioural memory with shared fault masks.
module tb_mem_bist_ctrl;

   typedef struct {
      int ec;
      int fea;
      bit pass;
      int lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic [7:0] seed;

   logic [7:0] mem_a [32];
   logic [7:0] mem_b [32];
   logic [7:0] or_m  [32];
   logic [7:0] xor_m [32];
   logic [7:0] dout_a, pb0, pb1, dout_b;

   int   checks = 0;
   int   errors = 0;
   int   viol   = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];

   mem_bist_if #(.AW(5), .DW(8), .ECW(8)) bus_a ();
   mem_bist_if #(.AW(5), .DW(8), .ECW(2)) bus_b ();

   assign bus_a.start        = start;
   assign bus_a.mode         = mode;
   assign bus_a.seed         = seed;
   assign bus_a.mem_data_out = dout_a;
   assign bus_b.start        = start;
   assign bus_b.mode         = mode;
   assign bus_b.seed         = seed;
   assign bus_b.mem_data_out = dout_b;

   mem_bist_ctrl #(.AW(5), .DW(8), .RD_LAT(1), .ECW(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   mem_bist_ctrl #(.AW(5), .DW(8), .RD_LAT(3), .ECW(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   // Memories: faults are applied on the read path so the write data stays clean.
   always @(posedge clk) begin
      if (bus_a.mem_write) mem_a[bus_a.mem_addr] <= bus_a.mem_data_in;
      if (bus_a.mem_read)
         dout_a <= (mem_a[bus_a.mem_addr] | or_m[bus_a.mem_addr]) ^ xor_m[bus_a.mem_addr];
      if (bus_b.mem_write) mem_b[bus_b.mem_addr] <= bus_b.mem_data_in;
      if (bus_b.mem_read)
         pb0 <= (mem_b[bus_b.mem_addr] | or_m[bus_b.mem_addr]) ^ xor_m[bus_b.mem_addr];
      pb1    <= pb0;
      dout_b <= pb1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.mem_write && bus_a.mem_read) viol++;
         if (!bus_a.mem_write && bus_a.mem_data_in !== 8'h00) viol++;
         if (bus_b.mem_write && bus_b.mem_read) viol++;
         if (!bus_b.mem_write && bus_b.mem_data_in !== 8'h00) viol++;
      end
   end

   function automatic logic [7:0] model_pat(input logic [1:0] m, input int a, input logic [7:0] sd);
      logic [7:0] v;
      v = (sd == 8'h00) ? 8'h01 : sd;
      case (m)
         2'b00: return 8'h00;
         2'b01: return 8'(a);
         2'b10: begin
            for (int i = 0; i < a; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
            return v;
         end
         default: return ((a % 2) == 1) ? 8'h55 : 8'hAA;
      endcase
   endfunction

   task automatic clear_faults();
      for (int i = 0; i < 32; i++) begin
         or_m[i]  = 8'h00;
         xor_m[i] = 8'h00;
      end
   endtask

   task automatic push_expect(input logic [1:0] m, input logic [7:0] sd);
      int n;
      int first;
      logic [7:0] e;
      logic [7:0] g;
      n = 0;
      first = 0;
      for (int i = 0; i < 32; i++) begin
         e = model_pat(m, i, sd);
         g = (e | or_m[i]) ^ xor_m[i];
         if (g !== e) begin
            if (n == 0) first = i;
            n++;
         end
      end
      sb_a.push_back('{ec: (n > 255) ? 255 : n, fea: first, pass: (n == 0), lat: 66});
      sb_b.push_back('{ec: (n > 3) ? 3 : n, fea: first, pass: (n == 0), lat: 68});
   endtask

   // Launches one test on both controllers, follows the bus cycle by cycle and
   // checks the queued expectations when each done pulse appears.
   task automatic run_test(input logic [1:0] m, input logic [7:0] sd, input bit repulse, input string name);
      exp_t ea, eb;
      int lat_a, lat_b, seq_err;
      int ec_a, ec_b, fea_a, fea_b;
      logic pass_a, pass_b, busy_a, busy_b;
      lat_a = -1; lat_b = -1; seq_err = 0;
      ec_a = 0; ec_b = 0; fea_a = 0; fea_b = 0;
      pass_a = 1'b0; pass_b = 1'b0; busy_a = 1'b1; busy_b = 1'b1;
      push_expect(m, sd);
      @(negedge clk);
      mode  = m;
      seed  = sd;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode  = ~m;
      seed  = ~sd;
      for (int k = 0; k < 200 && (lat_a < 0 || lat_b < 0); k++) begin
         if (k < 32) begin
            if (!(bus_a.mem_write === 1'b1 && bus_a.mem_addr === 5'(k) &&
                  bus_a.mem_data_in === model_pat(m, k, sd))) seq_err++;
            if (!(bus_b.mem_write === 1'b1 && bus_b.mem_addr === 5'(k) &&
                  bus_b.mem_data_in === model_pat(m, k, sd))) seq_err++;
         end else if (k < 64) begin
            if (!(bus_a.mem_read === 1'b1 && bus_a.mem_addr === 5'(k - 32))) seq_err++;
            if (!(bus_b.mem_read === 1'b1 && bus_b.mem_addr === 5'(k - 32))) seq_err++;
         end
         if (k == 0 && (bus_a.busy !== 1'b1 || bus_b.busy !== 1'b1)) seq_err++;
         if (bus_a.done === 1'b1 && lat_a < 0) begin
            lat_a = k; ec_a = int'(bus_a.err_count); fea_a = int'(bus_a.first_err_addr);
            pass_a = bus_a.pass; busy_a = bus_a.busy;
         end
         if (bus_b.done === 1'b1 && lat_b < 0) begin
            lat_b = k; ec_b = int'(bus_b.err_count); fea_b = int'(bus_b.first_err_addr);
            pass_b = bus_b.pass; busy_b = bus_b.busy;
         end
         if (repulse && k == 10) begin
            start = 1'b1;
            mode  = 2'b11;
         end
         if (repulse && k == 11) start = 1'b0;
         @(negedge clk);
      end
      ea = sb_a.pop_front();
      eb = sb_b.pop_front();
      checks++;
      if (seq_err !== 0) begin
         errors++;
         $display("[TB] FAIL %s bus_sequence: got %0d bad cycles, expected 0", name, seq_err);
      end
      checks++;
      if (lat_a !== ea.lat || lat_b !== eb.lat) begin
         errors++;
         $display("[TB] FAIL %s done_latency: got %0d/%0d, expected %0d/%0d", name, lat_a, lat_b, ea.lat, eb.lat);
      end
      checks++;
      if (ec_a !== ea.ec || ec_b !== eb.ec) begin
         errors++;
         $display("[TB] FAIL %s err_count: got %0d/%0d, expected %0d/%0d", name, ec_a, ec_b, ea.ec, eb.ec);
      end
      checks++;
      if (fea_a !== ea.fea || fea_b !== eb.fea) begin
         errors++;
         $display("[TB] FAIL %s first_err_addr: got %0d/%0d, expected %0d/%0d", name, fea_a, fea_b, ea.fea, eb.fea);
      end
      checks++;
      if (pass_a !== ea.pass || pass_b !== eb.pass) begin
         errors++;
         $display("[TB] FAIL %s pass: got %0b/%0b, expected %0b/%0b", name, pass_a, pass_b, ea.pass, eb.pass);
      end
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s busy_at_done: got %0b/%0b, expected 0/0", name, busy_a, busy_b);
      end
      $display("[TB] %s finished", name);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      mode  = 2'b00;
      seed  = 8'h00;
      clear_faults();
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_a.busy, bus_a.done, bus_a.pass, bus_a.mem_write, bus_a.mem_read} !== 5'b0 ||
          {bus_b.busy, bus_b.done, bus_b.pass, bus_b.mem_write, bus_b.mem_read} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b/%b, expected 00000/00000",
                  {bus_a.busy, bus_a.done, bus_a.pass, bus_a.mem_write, bus_a.mem_read},
                  {bus_b.busy, bus_b.done, bus_b.pass, bus_b.mem_write, bus_b.mem_read});
      end
      checks++;
      if ({bus_a.err_count, bus_a.first_err_addr, bus_a.mem_addr, bus_a.mem_data_in} !== 29'b0 ||
          {bus_b.err_count, bus_b.first_err_addr, bus_b.mem_addr, bus_b.mem_data_in} !== 23'b0) begin
         errors++;
         $display("[TB] FAIL reset_values: got %h/%h, expected 0/0",
                  {bus_a.err_count, bus_a.first_err_addr, bus_a.mem_addr, bus_a.mem_data_in},
                  {bus_b.err_count, bus_b.first_err_addr, bus_b.mem_addr, bus_b.mem_data_in});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_clear();
      clear_faults();
      run_test(2'b00, 8'h00, 1'b0, "clear");
   endtask

   task automatic test_addr_stuck();
      clear_faults();
      or_m[5] = 8'h08;
      run_test(2'b01, 8'h00, 1'b0, "addr_stuck");
   endtask

   task automatic test_rand();
      clear_faults();
      run_test(2'b10, 8'hA5, 1'b0, "rand_a5");
      run_test(2'b10, 8'h00, 1'b0, "rand_seed0");
   endtask

   task automatic test_checker();
      clear_faults();
      xor_m[6] = 8'hFF;
      xor_m[9] = 8'h01;
      run_test(2'b11, 8'h00, 1'b0, "checker_two");
   endtask

   task automatic test_saturate();
      clear_faults();
      xor_m[1]  = 8'h10;
      xor_m[3]  = 8'h10;
      xor_m[7]  = 8'h80;
      xor_m[20] = 8'h01;
      xor_m[31] = 8'h40;
      run_test(2'b11, 8'h00, 1'b0, "checker_sat");
   endtask

   task automatic test_reset_mid();
      bit hit;
      bit saw_done;
      hit = 1'b0;
      saw_done = 1'b0;
      clear_faults();
      @(negedge clk);
      mode  = 2'b01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         if (bus_a.mem_read === 1'b1 && bus_a.mem_addr === 5'd12) hit = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("[TB] FAIL reset_mid_reach: got no read at addr 12, expected one within 100 cycles");
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus_a.busy, bus_a.mem_read, bus_a.mem_write, bus_b.busy, bus_b.mem_read, bus_b.mem_write} !== 6'b0 ||
          bus_a.mem_addr !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_async: got %b addr %0d, expected 000000 addr 0",
                  {bus_a.busy, bus_a.mem_read, bus_a.mem_write, bus_b.busy, bus_b.mem_read, bus_b.mem_write},
                  bus_a.mem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (bus_a.done === 1'b1 || bus_b.done === 1'b1 || bus_a.busy === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("[TB] FAIL reset_mid_no_done: got done/busy after abort, expected none");
      end
      run_test(2'b01, 8'h00, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back();
      clear_faults();
      run_test(2'b01, 8'h00, 1'b1, "repulse");
      or_m[0] = 8'h01;
      run_test(2'b00, 8'h00, 1'b0, "back_to_back");
   endtask

   task automatic test_strobes();
      checks++;
      if (viol !== 0) begin
         errors++;
         $display("[TB] FAIL strobe_rules: got %0d violations, expected 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_addr_stuck();
      test_rand();
      test_checker();
      test_saturate();
      test_reset_mid();
      test_back_to_back();
      test_strobes();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
